// File: rtl/m_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// sizing helper for the digit counter.
package m_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Digit-counter width: clog2(width/digit), never narrower than one bit.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/m_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells; this is
// the only arithmetic shared by every digit of a serial operation.
module m_digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end

    assign cout = w_c[DIGIT];

endmodule

// File: rtl/m_serial_adder.sv
// Digit-serial adder/subtractor: captures WIDTH-bit operands on start and
// resolves DIGIT bits per clock through one shared m_digit_adder.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start; out holds the last completed result
// S_RUN  | one digit added per cycle, least-significant digit first
// S_DONE | one-cycle done pulse; out freshly valid, start ignored
module m_serial_adder
    import m_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   out
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH:0]   r_out;

    logic [DIGIT-1:0] w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;

    m_digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_b[DIGIT-1:0]),
        .cin  (r_c),
        .s    (w_s),
        .cout (w_cout)
    );

    // Sum digits enter A from the top as its consumed digits leave the bottom,
    // so after N digits r_a holds the assembled result without a second register.
    if (N > 1) begin : g_shift
        assign w_a_next = {w_s, r_a[WIDTH-1:DIGIT]};
        assign w_b_next = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    end else begin : g_single
        assign w_a_next = w_s;
        assign w_b_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= in1;
                        r_b     <= sub ? ~in2 : in2;
                        r_c     <= sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_next;
                    r_b   <= w_b_next;
                    r_c   <= w_cout;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_DIGIT) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_out   <= {w_cout, w_a_next};
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign out  = r_out;

endmodule
